// File: rtl/ram_access_sequencer.sv
// Single-port word RAM behind a BUSY/ACCESS latency handshake.
// Define RAM_JITTER_EN to add LFSR-driven random extra latency.
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module ram_access_sequencer
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output ramstate_t   ramstate
);
    localparam int IW = $clog2(DEPTH);
    localparam int KW = 1 + IW + 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACC  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_nstate;
    logic [3:0]    r_cnt;
    logic [3:0]    w_ncnt;
    logic [3:0]    w_load;
    logic [KW-1:0] r_key;
    logic [KW-1:0] w_key;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] r_idx;
    logic          w_req;
    logic          w_oor;
    logic          w_err;
    logic          w_match;
    logic          w_latch;
    logic          w_we;
    logic          w_hit;
    logic [31:0]   r_mem [DEPTH];

    assign w_req   = ramREN ^ ramWEN;
    assign w_oor   = (ramaddr >> (IW + 2)) != 32'd0;
    assign w_err   = (ramREN & ramWEN) | (w_req & w_oor);
    assign w_idx   = ramaddr[IW+1:2];
    assign w_key   = {ramWEN, w_idx, ramWEN ? ramstore : 32'd0};
    assign w_match = (w_key == r_key);
    assign r_idx   = r_key[32 +: IW];
    assign w_hit   = (r_state == ACC) & w_req & ~w_err & w_match;

`ifdef RAM_JITTER_EN
    logic [3:0] r_lfsr;
    logic [4:0] w_sum;

    assign w_sum  = 5'(LAT - 1) + {3'b000, r_lfsr[1:0]};
    assign w_load = (w_sum > 5'd15) ? 4'hF : w_sum[3:0];

    // x^4+x^3+1, advanced once per request accepted from IDLE
    always_ff @(posedge CLK) begin
        if (RST)
            r_lfsr <= 4'b1001;
        else if (w_latch && r_state == IDLE)
            r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
    end
`else
    assign w_load = 4'(LAT - 1);
`endif

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_latch  = 1'b0;
        w_we     = 1'b0;
        if (w_err) begin
            w_nstate = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        w_latch  = 1'b1;
                        w_ncnt   = w_load;
                        w_nstate = (w_load == 4'd0) ? ACC : WAIT;
                    end
                end
                WAIT: begin
                    if (!w_req) begin
                        w_nstate = IDLE;
                    end else if (!w_match) begin
                        w_latch  = 1'b1;
                        w_ncnt   = w_load;
                        w_nstate = (w_load == 4'd0) ? ACC : WAIT;
                    end else if (r_cnt == 4'd1) begin
                        w_nstate = ACC;
                    end else begin
                        w_ncnt = r_cnt - 4'd1;
                    end
                end
                ACC: begin
                    w_nstate = IDLE;
                    w_we     = w_hit & ramWEN;
                end
                default: w_nstate = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_key   <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            if (w_latch)
                r_key <= w_key;
        end
    end

    // Array is deliberately never cleared by reset
    always_ff @(posedge CLK) begin
        if (!RST && w_we)
            r_mem[r_idx] <= ramstore;
    end

    always_comb begin
        if (ramREN & ramWEN)
            ramstate = ERROR;
        else if (w_req & w_oor)
            ramstate = ERROR;
        else if (!w_req)
            ramstate = FREE;
        else if (r_state == ACC && w_match)
            ramstate = ACCESS;
        else
            ramstate = BUSY;
    end

    assign ramload = (w_hit & ramREN) ? r_mem[r_idx] : 32'd0;

endmodule
